// File: rtl/cirno9_boot_pkg.sv
// Shared constants and FSM state type for the cirno9 boot loader.
// Imported by the loader top and its byte packer.
package cirno9_boot_pkg;

    localparam int DEPTH     = 16384;
    localparam int ADDR_W    = 14;
    localparam int MAX_BYTES = 4 * DEPTH;
    localparam int LEN_W     = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE
    } boot_state_e;

endpackage

// File: rtl/cirno9_byte_packer.sv
// Packs a little-endian byte stream into one 32-bit word.
// Tracks the next lane index and per-lane write enables; clear zeroes everything.
module cirno9_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  push_data,
    output logic [31:0] word,
    output logic [3:0]  wem,
    output logic [1:0]  idx
);

    logic [31:0] word_q, word_d;
    logic [3:0]  wem_q, wem_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        word_d = word_q;
        wem_d  = wem_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            wem_d  = '0;
            idx_d  = '0;
        end else if (push) begin
            word_d[{idx_q, 3'b000} +: 8] = push_data;
            wem_d[idx_q]                 = 1'b1;
            idx_d                        = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            word_q <= '0;
            wem_q  <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            wem_q  <= wem_d;
            idx_q  <= idx_d;
        end
    end

    assign word = word_q;
    assign wem  = wem_q;
    assign idx  = idx_q;

endmodule

// File: rtl/cirno9_boot_loader.sv
// Streams a byte image into word-wide SRAM, then releases the cirno9 core.
// Length is checked up front so the word address can never wrap.
module cirno9_boot_loader #(
    parameter int DEPTH  = cirno9_boot_pkg::DEPTH,
    parameter int ADDR_W = cirno9_boot_pkg::ADDR_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [cirno9_boot_pkg::LEN_W-1:0]  len_bytes,
    input  logic                               in_vld,
    input  logic [7:0]                         in_data,
    output logic                               in_rdy,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [31:0]                        mem_wdata,
    output logic [3:0]                         mem_wem,
    input  logic                               mem_rdy,
    output logic                               core_rst_n,
    output logic                               done,
    output logic                               err
);

    import cirno9_boot_pkg::*;

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(4 * DEPTH);

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              push;
    logic              clear;
    logic [1:0]        idx;
    logic [31:0]       word;
    logic [3:0]        wem;

    cirno9_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data (in_data),
        .word      (word),
        .wem       (wem),
        .idx       (idx)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        err_d       = err_q;
        push        = 1'b0;
        clear       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_bytes == '0) begin
                        state_d = ST_DONE;
                    end else if ({1'b0, len_bytes} > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = len_bytes;
                        addr_d      = '0;
                        clear       = 1'b1;
                        state_d     = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (in_vld) begin
                    push        = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (idx == 2'd3 || remaining_q == LEN_W'(1)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_rdy) begin
                    clear = 1'b1;
                    // The address only advances when another word follows, so the last word never wraps it.
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_RECV;
                    end
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
        end
    end

    assign in_rdy     = (state_q == ST_RECV);
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = word;
    assign mem_wem    = wem;
    assign done       = (state_q == ST_DONE) && !err_q;
    assign core_rst_n = done;
    assign err        = err_q;

endmodule

// File: tb/tb_cirno9_boot_loader.sv
// Self-checking bench for cirno9_boot_loader: directed vector table, corner
// sequences (stall, mid-load reset, length bounds) and randomized loads.
module tb_cirno9_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] len_bytes;
    logic        in_vld;
    logic [7:0]  in_data;
    logic        in_rdy;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wem;
    logic        mem_rdy;
    logic        core_rst_n;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    cirno9_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_bytes  (len_bytes),
        .in_vld     (in_vld),
        .in_data    (in_data),
        .in_rdy     (in_rdy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wem    (mem_wem),
        .mem_rdy    (mem_rdy),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  wem;
    } wr_t;

    typedef struct packed {
        int          len;
        int          nb;
        logic [63:0] bytes;
        int          nw;
        logic [63:0] words;
        logic [7:0]  wems;
        logic        done_e;
        logic        err_e;
        int          cyc;
    } vec_t;

    wr_t  wlog[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_errors = 0;
    int   byte_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are already set; observe the handshakes they create, then advance to the next negedge.
    task automatic cycle();
        if (mem_we && mem_rdy) wlog.push_back({mem_addr, mem_wdata, mem_wem});
        if (in_vld && in_rdy) byte_idx++;
        @(negedge clk);
    endtask

    task automatic step(input logic [7:0] data[$], input int vld_pct, input int rdy_pct);
        in_vld  = (byte_idx < data.size()) && (int'($urandom_range(99)) < vld_pct);
        in_data = in_vld ? data[byte_idx] : 8'($urandom);
        mem_rdy = int'($urandom_range(99)) < rdy_pct;
        cycle();
    endtask

    task automatic begin_load(input int len);
        byte_idx = 0;
        wlog.delete();
        start     = 1'b1;
        len_bytes = 17'(len);
        in_vld    = 1'b0;
        mem_rdy   = 1'b0;
        cycle();
        start = 1'b0;
    endtask

    task automatic load(input logic [7:0] data[$], input int len, input int vld_pct,
                        input int rdy_pct, input int budget, output int cycles);
        begin_load(len);
        cycles = 1;
        while (!(done || err) && cycles < budget) begin
            step(data, vld_pct, rdy_pct);
            cycles++;
        end
        check("load_finished", done || err, 1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        len_bytes = '0;
        in_vld    = 1'b0;
        in_data   = '0;
        mem_rdy   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_rdy"}, in_rdy, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_wem"}, mem_wem, 0);
        check({tag, "_core_rst_n"}, core_rst_n, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Reference: byte i goes to word i/4, lane i%4; lanes with no byte stay zero and disabled.
    task automatic compare_log(input string tag, input logic [7:0] data[$]);
        int  nw;
        wr_t e;
        nw = (data.size() + 3) / 4;
        check({tag, "_nwrites"}, wlog.size(), nw);
        for (int w = 0; w < nw && w < wlog.size(); w++) begin
            e.addr = 14'(w);
            e.data = '0;
            e.wem  = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * w + l < data.size()) begin
                    e.data[8*l +: 8] = data[4*w+l];
                    e.wem[l]         = 1'b1;
                end
            end
            check($sformatf("%s_w%0d", tag, w), wlog[w], e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] d2[$];
        int         cyc;
        int         n;

        vecs[0] = '{len: 8, nb: 8, bytes: 64'h0010_0093_0000_0013, nw: 2,
                    words: {32'h0010_0093, 32'h0000_0013}, wems: 8'hFF,
                    done_e: 1'b1, err_e: 1'b0, cyc: 11};
        vecs[1] = '{len: 5, nb: 5, bytes: 64'h0000_00EE_DDCC_BBAA, nw: 2,
                    words: {32'h0000_00EE, 32'hDDCC_BBAA}, wems: 8'h1F,
                    done_e: 1'b1, err_e: 1'b0, cyc: 8};
        vecs[2] = '{len: 4, nb: 4, bytes: 64'h0403_0201, nw: 1,
                    words: {32'h0, 32'h0403_0201}, wems: 8'h0F,
                    done_e: 1'b1, err_e: 1'b0, cyc: 6};
        vecs[3] = '{len: 1, nb: 1, bytes: 64'h5A, nw: 1,
                    words: {32'h0, 32'h0000_005A}, wems: 8'h01,
                    done_e: 1'b1, err_e: 1'b0, cyc: 3};
        vecs[4] = '{len: 0, nb: 0, bytes: 64'h0, nw: 0, words: 64'h0, wems: 8'h00,
                    done_e: 1'b1, err_e: 1'b0, cyc: 1};
        vecs[5] = '{len: 65537, nb: 0, bytes: 64'h0, nw: 0, words: 64'h0, wems: 8'h00,
                    done_e: 1'b0, err_e: 1'b1, cyc: 1};

        // Values while reset is held.
        rst = 1'b1; start = 1'b0; len_bytes = '0; in_vld = 1'b0; in_data = '0; mem_rdy = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");

        // Directed vectors at full throughput.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            d.delete();
            for (int i = 0; i < vecs[v].nb; i++) d.push_back(vecs[v].bytes[8*i +: 8]);
            load(d, vecs[v].len, 100, 100, 200, cyc);
            check($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
            check($sformatf("v%0d_done", v), done, vecs[v].done_e);
            check($sformatf("v%0d_err", v), err, vecs[v].err_e);
            check($sformatf("v%0d_core_rst_n", v), core_rst_n, vecs[v].done_e);
            check($sformatf("v%0d_idle_in_rdy", v), in_rdy, 0);
            check($sformatf("v%0d_nwrites", v), wlog.size(), vecs[v].nw);
            for (int w = 0; w < vecs[v].nw && w < wlog.size(); w++) begin
                check($sformatf("v%0d_addr%0d", v, w), wlog[w].addr, w);
                check($sformatf("v%0d_data%0d", v, w), wlog[w].data, vecs[v].words[32*w +: 32]);
                check($sformatf("v%0d_wem%0d", v, w), wlog[w].wem, vecs[v].wems[4*w +: 4]);
            end
            // DONE must hold through further start pulses and stream traffic.
            start = 1'b1; len_bytes = 17'd4; in_vld = 1'b1; mem_rdy = 1'b1;
            repeat (3) cycle();
            start = 1'b0; in_vld = 1'b0;
            check($sformatf("v%0d_hold_done", v), {done, err, in_rdy, mem_we},
                  {vecs[v].done_e, vecs[v].err_e, 2'b00});
        end

        // Largest legal length is accepted.
        do_reset();
        begin_load(65536);
        check("max_len_in_rdy", in_rdy, 1);
        check("max_len_err", err, 0);

        // SRAM stall: three cycles of mem_rdy=0 with a byte waiting.
        do_reset();
        d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        begin_load(8);
        n = 0;
        while (!mem_we && n < 20) begin
            step(d, 100, 0);
            n++;
        end
        check("stall_reached_write", mem_we, 1);
        for (int k = 0; k < 3; k++) begin
            in_vld  = 1'b1;
            in_data = d[byte_idx];
            mem_rdy = 1'b0;
            check($sformatf("stall%0d_in_rdy", k), in_rdy, 0);
            check($sformatf("stall%0d_mem_we", k), mem_we, 1);
            check($sformatf("stall%0d_word", k), {mem_addr, mem_wdata, mem_wem},
                  {14'd0, 32'h0000_0013, 4'hF});
            cycle();
        end
        check("stall_no_write_yet", wlog.size(), 0);
        n = 0;
        while (!(done || err) && n < 100) begin
            step(d, 100, 100);
            n++;
        end
        compare_log("stall", d);
        check("stall_done", done, 1);

        // Reset after 6 of 8 bytes, then a clean 4-byte restart.
        do_reset();
        d.delete();
        for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
        begin_load(8);
        n = 0;
        while (byte_idx < 6 && n < 40) begin
            step(d, 100, 100);
            n++;
        end
        check("midrst_six_bytes", byte_idx, 6);
        #2 rst = 1'b1;
        in_vld = 1'b0; mem_rdy = 1'b0;
        #1 check_reset_outputs("midrst");
        d2.delete();
        for (int i = 0; i < 4; i++) d2.push_back(d[i]);
        compare_log("midrst", d2);
        @(negedge clk);
        rst = 1'b0;
        d2.delete();
        for (int i = 0; i < 4; i++) d2.push_back(8'($urandom));
        load(d2, 4, 100, 100, 50, cyc);
        compare_log("restart", d2);
        check("restart_done", done, 1);
        check("restart_core_rst_n", core_rst_n, 1);

        // Randomized loads with irregular stream and SRAM readiness.
        for (int t = 0; t < 20; t++) begin
            int len;
            len = int'($urandom_range(1, 40));
            d.delete();
            for (int i = 0; i < len; i++) d.push_back(8'($urandom));
            do_reset();
            load(d, len, 70, 60, 600, cyc);
            compare_log($sformatf("rnd%0d", t), d);
            check($sformatf("rnd%0d_done", t), {done, err, core_rst_n}, 3'b101);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
